fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter DWIDTH, default 32, giving the data word width.
REQ-003 The block SHALL have parameter AWIDTH, default 4, giving the downstream FIFO depth as 2**AWIDTH.
REQ-004 The block SHALL have parameter MAX_BURST, default 4, giving the maximum words per grant (1..2**AWIDTH).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-007 The block SHALL have port arst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port req_data_i, input, N_REQ*DWIDTH bits: requester i data in bits [i*DWIDTH+DWIDTH-1 : i*DWIDTH].
REQ-009 The block SHALL have port req_valid_i, input, N_REQ bits: per-requester word valid.
REQ-010 The block SHALL have port req_ready_o, output, N_REQ bits: per-requester word accepted.
REQ-011 The block SHALL have port fifo_data_o, output, DWIDTH bits: FIFO write data.
REQ-012 The block SHALL have port fifo_wrreq_o, output, 1 bit: FIFO write request.
REQ-013 The block SHALL have port fifo_usedw_i, input, AWIDTH+1 bits: FIFO fill level.
REQ-014 The block SHALL have port grant_o, output, N_REQ bits: one-hot current owner, all zero when idle.
REQ-015 The block SHALL have port grant_id_o, output, max(1,$clog2(N_REQ)) bits: binary index of the current owner.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high while in state GRANT.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-018 The block SHALL hold a round-robin pointer ptr of width grant_id_o.
REQ-019 In IDLE with any req_valid_i bit high, the block SHALL select the first valid index at or after ptr, wrapping modulo N_REQ, and enter GRANT next cycle with owner set to that index.
REQ-020 On each grant, ptr SHALL become (owner+1) mod N_REQ.
REQ-021 The block SHALL compute space_ok = (fifo_usedw_i + fifo_wrreq_o) < 2**AWIDTH, evaluated at AWIDTH+2 bits to avoid overflow.
REQ-022 req_ready_o[i] SHALL equal busy_o AND (owner==i) AND space_ok (combinational); all other bits SHALL be 0.
REQ-023 A transfer SHALL occur when req_valid_i[owner] and req_ready_o[owner] are both high.
REQ-024 On a transfer, fifo_data_o SHALL take the owner's word and fifo_wrreq_o SHALL be 1 on the next cycle; otherwise fifo_wrreq_o SHALL be 0 and fifo_data_o SHALL hold. Latency is 1 cycle.
REQ-025 A burst counter SHALL clear on grant and increment on each transfer.
REQ-026 GRANT SHALL return to IDLE after the transfer that brings the burst count to MAX_BURST.
REQ-027 GRANT SHALL return to IDLE in any GRANT cycle where req_valid_i[owner] is 0.
REQ-028 No transfer SHALL occur in IDLE; re-arbitration always costs one bubble cycle.
REQ-029 While space_ok is 0 in GRANT, the block SHALL hold the owner and burst count and SHALL NOT release on that account.
REQ-030 The block SHALL never drive fifo_wrreq_o such that the FIFO is written while full.

Reset
REQ-031 While arst_n_i is low, all of the following SHALL hold immediately, independent of clk_i: state IDLE, ptr 0, owner 0, burst count 0, fifo_wrreq_o 0, fifo_data_o 0, grant_o 0, grant_id_o 0, busy_o 0, req_ready_o 0.
REQ-032 Reset assertion mid-burst SHALL discard the burst with no further writes; the first grant after release SHALL use ptr 0.

Verification
REQ-033 All four requesters valid from reset, usedw 0, FIFO drained each cycle -> grants in order 0,1,2,3,0; 4 writes each, 1 idle bubble between grants.
REQ-034 fifo_usedw_i=15 and fifo_wrreq_o=1 -> req_ready_o=0 the next cycle; fifo_usedw_i=14 and fifo_wrreq_o=0 -> ready=1.
REQ-035 Owner 3 releases while requesters 1 and 3 are valid -> next grant_id_o=1 (ptr wrapped to 0).
REQ-036 Requester 2 alone drops valid after 2 words -> IDLE next cycle, exactly 2 fifo_wrreq_o pulses carrying its data in order.
REQ-037 arst_n_i asserted after word 2 of a 4-word burst -> all outputs 0 asynchronously; after release, requester 0 is granted first if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters write bursts into one downstream FIFO.
// A grant lasts until MAX_BURST words have moved or the owner drops valid; FIFO fullness stalls it.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IdW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]       fifo_data_o,
    output logic                    fifo_wrreq_o,
    input  logic [AWIDTH:0]         fifo_usedw_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic [IdW-1:0]          grant_id_o,
    output logic                    busy_o
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [AWIDTH+1:0] FifoDepth = {2'b01, {AWIDTH{1'b0}}};

    typedef enum logic {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              wrreq_q, wrreq_d;
    logic [DWIDTH-1:0] data_q, data_d;

    logic [AWIDTH+1:0]  fill;
    logic               space_ok;
    logic               busy;
    logic               owner_valid;
    logic [DWIDTH-1:0]  owner_word;
    logic [2*N_REQ-1:0] rot;
    int unsigned        off;
    int unsigned        sel;
    int unsigned        sel_nxt;

    // The write registered last cycle is not yet visible in usedw, so count it here.
    assign fill     = {1'b0, fifo_usedw_i} + {{(AWIDTH+1){1'b0}}, wrreq_q};
    assign space_ok = fill < FifoDepth;
    assign busy     = (state_q == StGrant);

    always_comb begin
        owner_valid = 1'b0;
        owner_word  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IdW'(i)) begin
                owner_valid = req_valid_i[i];
                owner_word  = req_data_i[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot     = {req_valid_i, req_valid_i} >> ptr_q;
        off     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
            end
        end
        sel = 32'(ptr_q) + off;
        if (sel >= N_REQ) begin
            sel = sel - N_REQ;
        end
        sel_nxt = sel + 1;
        if (sel_nxt >= N_REQ) begin
            sel_nxt = 0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    state_d = StGrant;
                    owner_d = IdW'(sel);
                    ptr_d   = IdW'(sel_nxt);
                    burst_d = '0;
                end
            end
            StGrant: begin
                if (!owner_valid) begin
                    state_d = StIdle;
                end else if (space_ok) begin
                    wrreq_d = 1'b1;
                    data_d  = owner_word;
                    burst_d = burst_q + BW'(1);
                    if (burst_q == BW'(MAX_BURST - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            wrreq_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_o[i]     = busy && (owner_q == IdW'(i));
            req_ready_o[i] = busy && (owner_q == IdW'(i)) && space_ok;
        end
    end

    assign fifo_data_o  = data_q;
    assign fifo_wrreq_o = wrreq_q;
    assign grant_id_o   = owner_q;
    assign busy_o       = busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected grants and FIFO writes are queued up front,
// a monitor pops them as the DUT starts grants and pulses fifo_wrreq_o.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    fifo_data;
    logic             fifo_wrreq;
    logic [AW:0]      fifo_usedw;
    logic [NR-1:0]    grant;
    logic [1:0]       grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          gap;
    } wr_t;

    wr_t         wq[$];
    logic [1:0]  gq[$];

    int unsigned rem[NR];
    int unsigned seq[NR];
    logic [NR-1:0] en;
    logic [NR-1:0] acc;
    logic [7:0]    tag;

    fifo_wr_arbiter #(
        .N_REQ    (NR),
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .MAX_BURST(4)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .fifo_data_o (fifo_data),
        .fifo_wrreq_o(fifo_wrreq),
        .fifo_usedw_i(fifo_usedw),
        .grant_o     (grant),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] t, input int i, input int unsigned s);
        return {t, 8'(i), 16'(s)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_grant"}, 32'(grant), 32'(0));
        check({name, "_grant_id"}, 32'(grant_id), 32'(0));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_ready"}, 32'(req_ready), 32'(0));
        check({name, "_wrreq"}, 32'(fifo_wrreq), 32'(0));
        check({name, "_data"}, fifo_data, 32'(0));
    endtask

    task automatic set_src(input int i, input int unsigned n);
        rem[i] = n;
        seq[i] = 0;
    endtask

    task automatic exp_wr(input int i, input int unsigned s, input int gap);
        wr_t e;
        e.data = word(tag, i, s);
        e.gap  = gap;
        wq.push_back(e);
    endtask

    // Drive at the falling edge; a requester advances to its next word once accepted.
    task automatic step(input logic [AW:0] uw);
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                seq[i] = seq[i] + 1;
                rem[i] = rem[i] - 1;
            end
        end
        fifo_usedw = uw;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = en[i] && (rem[i] != 0);
            req_data[i*DW +: DW]  = word(tag, i, seq[i]);
        end
        #1;
        acc = arst_n ? (req_valid & req_ready) : '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((wq.size() != 0 || gq.size() != 0) && n < budget) begin
            step(0);
            n++;
        end
        check({name, "_writes_left"}, 32'(wq.size()), 32'(0));
        check({name, "_grants_left"}, 32'(gq.size()), 32'(0));
        repeat (3) step(0);
        check({name, "_idle_busy"}, 32'(busy), 32'(0));
    endtask

    // Monitor: compare grant starts and FIFO writes against the queued expectations.
    initial begin
        int   cyc = 0;
        int   last_cyc = 0;
        logic busy_prev = 1'b0;
        wr_t  e;
        logic [1:0] g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && !busy_prev) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got id %0d, expected none", grant_id);
                end else begin
                    g = gq.pop_front();
                    check("grant_id", 32'(grant_id), 32'(g));
                    check("grant_onehot", 32'(grant), 32'(4'b0001 << g));
                end
            end
            busy_prev = busy;
            if (fifo_wrreq) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h, expected no write", fifo_data);
                end else begin
                    e = wq.pop_front();
                    check("wr_data", fifo_data, e.data);
                    if (e.gap != 0) begin
                        check("wr_gap", 32'(cyc - last_cyc), 32'(e.gap));
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n     = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        fifo_usedw = '0;
        en         = '0;
        acc        = '0;
        tag        = 8'd1;
        for (int i = 0; i < NR; i++) set_src(i, 0);

        // All four valid from reset: bursts of 4 in order 0,1,2,3,0 with one bubble between.
        set_src(0, 8);
        set_src(1, 4);
        set_src(2, 4);
        set_src(3, 4);
        en = 4'b1111;
        repeat (3) step(0);
        check_zero("reset");
        arst_n = 1'b1;
        gq.push_back(2'd0);
        gq.push_back(2'd1);
        gq.push_back(2'd2);
        gq.push_back(2'd3);
        gq.push_back(2'd0);
        for (int r = 0; r < NR; r++) begin
            for (int s = 0; s < 4; s++) begin
                exp_wr(r, s, (r == 0 && s == 0) ? 0 : ((s == 0) ? 2 : 1));
            end
        end
        for (int s = 4; s < 8; s++) exp_wr(0, s, (s == 4) ? 2 : 1);
        drain("rr4", 100);

        // FIFO space: ready follows usedw + pending write against depth 16.
        tag = 8'd2;
        en  = 4'b0001;
        set_src(0, 3);
        gq.push_back(2'd0);
        exp_wr(0, 0, 0);
        exp_wr(0, 1, 2);
        exp_wr(0, 2, 1);
        step(14);
        check("idle_ready", 32'(req_ready), 32'(0));
        step(14);
        check("ready_used14_wr0", 32'(req_ready), 32'(4'b0001));
        step(15);
        check("wrreq_pending", 32'(fifo_wrreq), 32'(1));
        check("ready_used15_wr1", 32'(req_ready), 32'(0));
        check("stall_busy", 32'(busy), 32'(1));
        step(15);
        check("ready_used15_wr0", 32'(req_ready), 32'(4'b0001));
        step(0);
        check("after_stall_grant", 32'(grant), 32'(4'b0001));
        drain("space", 20);

        // Owner 3 ends its burst while 1 and 3 are valid: pointer wrapped, so 1 goes next.
        tag = 8'd3;
        en  = 4'b1000;
        set_src(1, 4);
        set_src(3, 6);
        gq.push_back(2'd3);
        gq.push_back(2'd1);
        gq.push_back(2'd3);
        for (int s = 0; s < 4; s++) exp_wr(3, s, (s == 0) ? 0 : 1);
        for (int s = 0; s < 4; s++) exp_wr(1, s, (s == 0) ? 2 : 1);
        exp_wr(3, 4, 2);
        exp_wr(3, 5, 1);
        step(0);
        en = 4'b1010;
        drain("wrap", 60);

        // Requester 2 alone stops after two words: release on the next edge.
        tag = 8'd4;
        en  = 4'b0100;
        set_src(1, 0);
        set_src(3, 0);
        set_src(2, 2);
        gq.push_back(2'd2);
        exp_wr(2, 0, 0);
        exp_wr(2, 1, 1);
        step(0);
        step(0);
        step(0);
        step(0);
        check("drop_still_busy", 32'(busy), 32'(1));
        check("drop_valid_low", 32'(req_valid), 32'(0));
        step(0);
        check("drop_idle_busy", 32'(busy), 32'(0));
        check("drop_idle_grant", 32'(grant), 32'(0));
        drain("drop", 20);

        // Reset after the second word of a burst: outputs clear at once, pointer back to 0.
        tag = 8'd5;
        en  = 4'b0010;
        set_src(1, 4);
        gq.push_back(2'd1);
        exp_wr(1, 0, 0);
        exp_wr(1, 1, 1);
        step(0);
        step(0);
        step(0);
        step(0);
        check("pre_reset_wrreq", 32'(fifo_wrreq), 32'(1));
        arst_n = 1'b0;
        acc    = '0;
        #1;
        check_zero("async_reset");
        tag = 8'd6;
        en  = 4'b0011;
        set_src(0, 1);
        set_src(1, 1);
        gq.push_back(2'd0);
        gq.push_back(2'd1);
        exp_wr(0, 0, 0);
        exp_wr(1, 0, 3);
        step(0);
        step(0);
        check_zero("reset_hold");
        arst_n = 1'b1;
        drain("post_reset", 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
